cache_data_store: RTL and testbench

//  Parametrised N-way set-associative cache data storage: successor to the fixed 4-way/128-set/512-bit data array.

---
 rtl/cache_data_store.sv | 136 +++++++++++++
 tb/tb_cache_data_store.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_store.sv
// cache_data_store
//   N-way set-associative cache data array with registered reads, byte-enable
//   word writes, block fills and a set-by-set clear engine that runs after
//   reset and on request.
// Ports
//   clk, reset          clock; synchronous active-high reset
//   clear_req           pulse: start clearing all sets (ignored while clearing)
//   busy                clear engine running, no requests accepted
//   req_valid/req_ready request handshake; accepted when both high
//   req_op              0 READ, 1 FILL, 2 WORD, 3 reserved (flagged as error)
//   req_index           set index
//   req_way             FILL target way
//   req_hit_way         WORD way mask (multi-hot writes every selected way)
//   req_offset, req_be  WORD word offset and byte enables
//   req_block, req_word FILL / WORD data
//   rd_valid, rd_data   READ result one cycle after acceptance, all ways
//   err                 one-cycle pulse for an accepted malformed request
//
// state  | meaning
// CLEAR  | zeroing set clr_idx in every way, one set per cycle
// IDLE   | accepting requests
module cache_data_store #(
  parameter int NUM_WAYS   = 4,
  parameter int NUM_SETS   = 128,
  parameter int BLOCK_BITS = 512,
  parameter int WORD_BITS  = 32,
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int INDEX_W   = $clog2(NUM_SETS),
  localparam int WORDS     = BLOCK_BITS / WORD_BITS,
  localparam int OFF_W     = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int BE_W      = WORD_BITS / 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear_req,
  output logic                           busy,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [INDEX_W-1:0]             req_index,
  input  logic [WAY_W-1:0]               req_way,
  input  logic [NUM_WAYS-1:0]            req_hit_way,
  input  logic [OFF_W-1:0]               req_offset,
  input  logic [BE_W-1:0]                req_be,
  input  logic [BLOCK_BITS-1:0]          req_block,
  input  logic [WORD_BITS-1:0]           req_word,
  output logic                           rd_valid,
  output logic [NUM_WAYS*BLOCK_BITS-1:0] rd_data,
  output logic                           err
);

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_SETS - 1);
  localparam logic [WAY_W:0]     WAYS_L   = (WAY_W + 1)'(NUM_WAYS);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t             state, state_nxt;
  logic [INDEX_W-1:0] clr_idx;
  logic [BLOCK_BITS-1:0] mem [NUM_WAYS][NUM_SETS];

  logic accept, way_ok, do_read, do_fill, do_word, bad_req;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_idx == LAST_IDX) state_nxt = ST_IDLE;
      ST_IDLE:  if (clear_req)           state_nxt = ST_CLEAR;
      default:                           state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    busy      = (state == ST_CLEAR);
    req_ready = (state == ST_IDLE) && !reset;
  end

  // Restarting from zero on every entry into CLEAR keeps the sweep complete
  // even if a reset interrupts it part way.
  always_ff @(posedge clk) begin
    if (reset)                  clr_idx <= '0;
    else if (state == ST_CLEAR) clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
    else                        clr_idx <= '0;
  end

  always_comb begin
    accept  = req_valid && req_ready;
    way_ok  = ({1'b0, req_way} < WAYS_L);
    do_read = accept && (req_op == 2'd0);
    do_fill = accept && (req_op == 2'd1) && way_ok;
    do_word = accept && (req_op == 2'd2);
    bad_req = accept && ((req_op == 2'd3) ||
                         ((req_op == 2'd1) && !way_ok) ||
                         ((req_op == 2'd2) && (req_hit_way == '0)));
  end

  // Storage has no reset of its own; the clear engine sweeps it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        for (int w = 0; w < NUM_WAYS; w++) mem[w][clr_idx] <= '0;
      end else begin
        if (do_fill) mem[req_way][req_index] <= req_block;
        if (do_word) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            for (int b = 0; b < BE_W; b++) begin
              if (req_hit_way[w] && req_be[b])
                mem[w][req_index][int'(req_offset) * WORD_BITS + 8 * b +: 8] <= req_word[8 * b +: 8];
            end
          end
        end
      end
    end
  end

  // rd_data only changes on a READ, so it survives a clear sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= do_read;
      err      <= bad_req;
      if (do_read) begin
        for (int w = 0; w < NUM_WAYS; w++)
          rd_data[w * BLOCK_BITS +: BLOCK_BITS] <= mem[w][req_index];
      end
    end
  end

endmodule

// File: tb/tb_cache_data_store.sv
module tb_cache_data_store;

  localparam int NW   = 4;
  localparam int NS   = 128;
  localparam int BB   = 512;
  localparam int WB   = 32;
  localparam int WAYW = 2;
  localparam int IW   = 7;
  localparam int OW   = 4;
  localparam int NBE  = WB / 8;
  localparam int DW   = NW * BB;

  logic          clk, reset, clear_req, busy, req_valid, req_ready;
  logic [1:0]    req_op;
  logic [IW-1:0] req_index;
  logic [WAYW-1:0] req_way;
  logic [NW-1:0] req_hit_way;
  logic [OW-1:0] req_offset;
  logic [NBE-1:0] req_be;
  logic [BB-1:0] req_block;
  logic [WB-1:0] req_word;
  logic          rd_valid, err;
  logic [DW-1:0] rd_data;

  cache_data_store #(.NUM_WAYS(NW), .NUM_SETS(NS), .BLOCK_BITS(BB), .WORD_BITS(WB)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_way(req_way), .req_hit_way(req_hit_way),
    .req_offset(req_offset), .req_be(req_be), .req_block(req_block),
    .req_word(req_word), .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [BB-1:0] model [NW][NS];
  logic [DW-1:0] last_read;
  int            checks   = 0;
  int            failures = 0;

  function automatic logic [DW-1:0] model_set(input int idx);
    logic [DW-1:0] d;
    for (int w = 0; w < NW; w++) d[w * BB +: BB] = model[w][idx];
    return d;
  endfunction

  function automatic logic [BB-1:0] rand_blk();
    logic [BB-1:0] b;
    for (int i = 0; i < BB / 32; i++) b[i * 32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic model_zero();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++) model[w][s] = '0;
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_valid || err) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output rd_valid=%0b err=%0b required none", rd_valid, err);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_err) begin
          if (!(err && !rd_valid)) begin
            failures++;
            $display("FAIL err_pulse got err=%0b rd_valid=%0b required err=1 rd_valid=0", err, rd_valid);
          end
        end else if (!(rd_valid && !err) || rd_data !== mon_e.data) begin
          int fw;
          fw = -1;
          for (int i = 0; i < DW / WB; i++)
            if (fw < 0 && rd_data[i * WB +: WB] !== mon_e.data[i * WB +: WB]) fw = i;
          if (fw < 0) fw = 0;
          failures++;
          $display("FAIL read_data rd_valid=%0b err=%0b word=%0d got=%h required=%h",
                   rd_valid, err, fw, rd_data[fw * WB +: WB], mon_e.data[fw * WB +: WB]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  // Issue one request (optionally with clear_req); the model applies the rule at once.
  task automatic issue(input logic [1:0] op, input int idx, input int way,
                       input logic [NW-1:0] hit, input int off, input logic [NBE-1:0] be,
                       input logic [BB-1:0] blk, input logic [WB-1:0] word, input bit clr);
    exp_t e;
    req_valid   = 1'b1;
    req_op      = op;
    req_index   = IW'(idx);
    req_way     = WAYW'(way);
    req_hit_way = hit;
    req_offset  = OW'(off);
    req_be      = be;
    req_block   = blk;
    req_word    = word;
    clear_req   = clr;
    check("ready", {63'd0, req_ready}, 64'd1);
    case (op)
      2'd0: begin
        e.is_err = 1'b0; e.data = model_set(idx);
        exp_q.push_back(e); last_read = e.data;
      end
      2'd1: model[way][idx] = blk;
      2'd2: begin
        if (hit == '0) begin
          e.is_err = 1'b1; e.data = '0; exp_q.push_back(e);
        end else begin
          for (int w = 0; w < NW; w++)
            for (int b = 0; b < NBE; b++)
              if (hit[w] && be[b]) model[w][idx][off * WB + 8 * b +: 8] = word[8 * b +: 8];
        end
      end
      default: begin
        e.is_err = 1'b1; e.data = '0; exp_q.push_back(e);
      end
    endcase
    if (clr) model_zero();
    @(posedge clk); #1;
    req_valid = 1'b0;
    clear_req = 1'b0;
  endtask

  // Counts busy cycles while offering junk fills that must not be consumed.
  task automatic wait_busy(input string name);
    int n, bad;
    bit done;
    n = 0; bad = 0; done = 0;
    req_valid = 1'b1; req_op = 2'd1; req_way = 2'd1;
    req_index = IW'($urandom_range(0, NS - 1)); req_block = rand_blk();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
      n++;
      if (req_ready) bad++;
    end
    req_valid = 1'b0;
    check({name, "_done"}, {63'd0, done}, 64'd1);
    check({name, "_cycles"}, 64'(n), 64'(NS));
    check({name, "_ready_low"}, 64'(bad), 64'd0);
  endtask

  logic [BB-1:0] blk7;

  initial begin
    reset = 1'b1; clear_req = 1'b0; req_valid = 1'b0; req_op = '0; req_index = '0;
    req_way = '0; req_hit_way = '0; req_offset = '0; req_be = '0; req_block = '0; req_word = '0;
    last_read = '0;
    model_zero();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_rd_data", {63'd0, (rd_data == '0)}, 64'd1);
    reset = 1'b0;

    // Reset while clr_idx = 60 restarts the sweep.
    repeat (60) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    check("midclr_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    wait_busy("busy_after_reset");

    // Freshly cleared array reads zero.
    issue(2'd0, 5, 0, '0, 0, '0, '0, '0, 0);

    // Fill way 2 set 7 and read it back.
    for (int k = 0; k < BB / WB; k++) blk7[k * WB +: WB] = 32'hA5A5_0000 + WB'(k);
    issue(2'd1, 7, 2, '0, 0, '0, blk7, '0, 0);
    issue(2'd0, 7, 0, '0, 0, '0, '0, '0, 0);

    // Partial byte write into way 2 word 3.
    issue(2'd2, 7, 0, 4'b0100, 3, 4'b0101, '0, 32'hDEADBEEF, 0);
    issue(2'd0, 7, 0, '0, 0, '0, '0, '0, 0);
    check("word3_way2", 64'(rd_data[2 * BB + 3 * WB +: WB]), 64'h0000_0000_A5AD_00EF);

    // Multi-hot write, empty mask error, zero byte enables.
    issue(2'd2, 7, 0, 4'b1001, 15, 4'hF, '0, 32'h12345678, 0);
    issue(2'd2, 7, 0, 4'b0000, 2, 4'hF, '0, 32'hFFFFFFFF, 0);
    issue(2'd2, 7, 0, 4'b0110, 1, 4'h0, '0, 32'hFFFFFFFF, 0);
    issue(2'd3, 7, 0, '0, 0, '0, '0, '0, 0);
    issue(2'd0, 7, 0, '0, 0, '0, '0, '0, 0);
    check("word15_way3", 64'(rd_data[3 * BB + 15 * WB +: WB]), 64'h0000_0000_1234_5678);

    // Read coinciding with clear_req returns pre-clear data; rd_data then holds.
    issue(2'd0, 7, 0, '0, 0, '0, '0, '0, 1);
    wait_busy("busy_clear_req");
    check("hold_after_clear", {63'd0, (rd_data === last_read)}, 64'd1);
    issue(2'd0, 7, 0, '0, 0, '0, '0, '0, 0);
    issue(2'd0, 0, 0, '0, 0, '0, '0, '0, 0);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      int r, idx;
      bit clr;
      r   = $urandom_range(0, 99);
      idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NS - 1) : $urandom_range(0, 7);
      clr = ($urandom_range(0, 59) == 0);
      if (r < 8) begin
        req_valid = 1'b0; req_op = 2'($urandom); req_index = IW'(idx);
        req_hit_way = '1; req_be = '1; req_word = $urandom; req_block = rand_blk();
        @(posedge clk); #1;
      end else begin
        logic [1:0] op;
        logic [NW-1:0] hit;
        op  = (r < 35) ? 2'd0 : (r < 55) ? 2'd1 : (r < 92) ? 2'd2 : 2'd3;
        hit = ($urandom_range(0, 2) == 0) ? NW'($urandom_range(0, 15)) : NW'(1 << $urandom_range(0, NW - 1));
        issue(op, idx, $urandom_range(0, NW - 1), hit, $urandom_range(0, BB / WB - 1),
              NBE'($urandom_range(0, 15)), rand_blk(), $urandom, clr);
        if (clr) wait_busy("busy_random_clear");
      end
    end

    // Reset after traffic clears outputs and the array.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst2_rd_data", {63'd0, (rd_data == '0)}, 64'd1);
    check("rst2_rd_valid", {63'd0, rd_valid}, 64'd0);
    reset = 1'b0;
    model_zero();
    wait_busy("busy_final_reset");
    issue(2'd0, 3, 0, '0, 0, '0, '0, '0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
